// File: rtl/systolic_skew_buffer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_buffer
// Brief    : Per-lane delay lines that add (DIR=0) or remove (DIR=1) the
//            diagonal skew of a systolic-array operand wavefront.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_buffer #(
    parameter int CHANNELS   = 8,
    parameter int BITS       = 64,
    parameter int BASE_DEPTH = 1,
    parameter int DIR        = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [CHANNELS*BITS-1:0] d,
    output logic [CHANNELS*BITS-1:0] q,
    output logic [CHANNELS-1:0]      q_valid,
    output logic                     all_valid,
    output logic                     drained
);

    // One bit per lane: any valid bit anywhere in that lane's stages.
    logic [CHANNELS-1:0] w_lane_busy;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        localparam int c_depth = BASE_DEPTH + ((DIR != 0) ? (CHANNELS - 1 - c) : c);

        logic [BITS-1:0]    r_data [c_depth];
        logic [c_depth-1:0] r_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < c_depth; i++) begin
                    r_data[i] <= '0;
                end
                r_vld <= '0;
            end else if (clr) begin
                for (int i = 0; i < c_depth; i++) begin
                    r_data[i] <= '0;
                end
                r_vld <= '0;
            end else if (en) begin
                // Idle cycles inject zeros so the array sees clean padding.
                r_data[0] <= in_valid ? d[c*BITS +: BITS] : '0;
                r_vld[0]  <= in_valid;
                for (int i = 1; i < c_depth; i++) begin
                    r_data[i] <= r_data[i-1];
                    r_vld[i]  <= r_vld[i-1];
                end
            end
        end

        assign q[c*BITS +: BITS] = r_data[c_depth-1];
        assign q_valid[c]        = r_vld[c_depth-1];
        assign w_lane_busy[c]    = |r_vld;
    end

    assign all_valid = &q_valid;
    assign drained   = ~|w_lane_busy;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_buffer
// Brief    : Self-checking bench for skew (DIR=0) and deskew (DIR=1) instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_buffer;

    localparam int CH = 4;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic [CH*BW-1:0] d = '0;

    logic [CH*BW-1:0] q0, q1;
    logic [CH-1:0]    qv0, qv1;
    logic             av0, av1, dr0, dr1;

    int checks = 0;
    int failures = 0;

    systolic_skew_buffer #(.CHANNELS(CH), .BITS(BW), .BASE_DEPTH(1), .DIR(0)) u_skew (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .d(d),
        .q(q0), .q_valid(qv0), .all_valid(av0), .drained(dr0)
    );

    systolic_skew_buffer #(.CHANNELS(CH), .BITS(BW), .BASE_DEPTH(1), .DIR(1)) u_deskew (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in_valid(in_valid), .d(d),
        .q(q1), .q_valid(qv1), .all_valid(av1), .drained(dr1)
    );

    always #5 clk = ~clk;

    // Reference model: history of wavefronts accepted on enabled edges since
    // the last reset/clear. Lane c of a buffer shows the entry D(c) back.
    typedef struct {
        logic             v;
        logic [CH*BW-1:0] d;
    } wf_t;
    wf_t hist[$];

    function automatic int depth_of(int dir, int c);
        return 1 + ((dir != 0) ? (CH - 1 - c) : c);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        for (int dir = 0; dir < 2; dir++) begin
            logic [CH*BW-1:0] eq  = '0;
            logic [CH-1:0]    ev  = '0;
            logic             edr = 1'b1;
            int               n   = hist.size();
            for (int c = 0; c < CH; c++) begin
                int dd = depth_of(dir, c);
                if (n >= dd && hist[n-dd].v) begin
                    ev[c] = 1'b1;
                    eq[c*BW +: BW] = hist[n-dd].d[c*BW +: BW];
                end
                for (int k = 1; k <= dd && k <= n; k++)
                    if (hist[n-k].v) edr = 1'b0;
            end
            if (dir == 0) begin
                chk("skew_q", 64'(q0), 64'(eq));
                chk("skew_qv", 64'(qv0), 64'(ev));
                chk("skew_all", 64'(av0), 64'(&ev));
                chk("skew_drained", 64'(dr0), 64'(edr));
            end else begin
                chk("deskew_q", 64'(q1), 64'(eq));
                chk("deskew_qv", 64'(qv1), 64'(ev));
                chk("deskew_all", 64'(av1), 64'(&ev));
                chk("deskew_drained", 64'(dr1), 64'(edr));
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model on the edge, compare after.
    task automatic cyc(logic i_en, logic i_clr, logic i_iv, logic [CH*BW-1:0] i_d);
        wf_t w;
        en = i_en; clr = i_clr; in_valid = i_iv; d = i_d;
        @(posedge clk);
        if (i_clr) begin
            hist.delete();
        end else if (i_en) begin
            w.v = i_iv;
            w.d = i_d;
            hist.push_back(w);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic             en, clr, iv;
        logic [CH*BW-1:0] d;
        logic [CH*BW-1:0] eq;
        logic [CH-1:0]    ev;
        logic             eall, edr;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int av_cnt, av_first, av_last;
        logic [CH*BW-1:0] av_q;

        tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h44332211, 32'h00000011, 4'b0001, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00002200, 4'b0010, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00330000, 4'b0100, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h44000000, 4'b1000, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 1'b0, 1'b1};

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset_q", 64'(q0), 64'h0);
        chk("reset_qv", 64'(qv0), 64'h0);
        chk("reset_drained", 64'(dr0 & dr1), 64'h1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        hist.delete();
        cmp_model();

        // Skew of a single wavefront, table-driven
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].en, tbl[i].clr, tbl[i].iv, tbl[i].d);
            chk($sformatf("tbl%0d_q", i), 64'(q0), 64'(tbl[i].eq));
            chk($sformatf("tbl%0d_qv", i), 64'(qv0), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_all", i), 64'(av0), 64'(tbl[i].eall));
            chk($sformatf("tbl%0d_drained", i), 64'(dr0), 64'(tbl[i].edr));
        end

        // Stall: freeze for three cycles after edge 2
        cyc(1, 0, 1, 32'h44332211);
        cyc(1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 32'h99999999);
            chk("stall_lane1", 64'(q0[15:8]), 64'h22);
            chk("stall_qv", 64'(qv0), 64'b0010);
        end
        cyc(1, 0, 0, 32'h0);
        chk("stall_lane2", 64'(q0[23:16]), 64'h33);
        cyc(1, 0, 0, 32'h0);
        chk("stall_lane3", 64'(q0[31:24]), 64'h44);
        cyc(1, 0, 0, 32'h0);

        // Clear wins over enable and discards the word presented that edge
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, $urandom());
        cyc(1, 1, 1, 32'hDEADBEEF);
        chk("clr_q", 64'(q0 | q1), 64'h0);
        chk("clr_qv", 64'(qv0 | qv1), 64'h0);
        chk("clr_drained", 64'(dr0 & dr1), 64'h1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 32'h0);

        // Deskew: lane with the deepest delay fed first aligns the wavefront
        av_cnt = 0; av_q = '0;
        for (int t = 0; t < 9; t++) begin
            logic [CH*BW-1:0] w = '0;
            if (t < CH) w[t*BW +: BW] = 8'(8'hA0 + t);
            cyc(1, 0, (t < CH), w);
            if (av1) begin av_cnt++; av_q = q1; end
        end
        chk("deskew_all_cnt", 64'(av_cnt), 64'd1);
        chk("deskew_aligned_q", 64'(av_q), 64'hA3A2A1A0);

        // Streaming: 16 back-to-back wavefronts through the skew instance
        av_cnt = 0; av_first = -1; av_last = -1;
        for (int n = 0; n < 22; n++) begin
            logic [CH*BW-1:0] w = '0;
            for (int c = 0; c < CH; c++) w[c*BW +: BW] = 8'(16*c + n);
            cyc(1, 0, (n < 16), w);
            if (av0) begin
                av_cnt++;
                if (av_first < 0) av_first = n + 1;
                av_last = n + 1;
            end
        end
        chk("stream_all_cnt", 64'(av_cnt), 64'd13);
        chk("stream_all_first", 64'(av_first), 64'd4);
        chk("stream_all_last", 64'(av_last), 64'd16);

        // Asynchronous reset mid-flight
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, $urandom());
        #2 rst_n = 1'b0;
        #1;
        chk("areset_q", 64'(q0 | q1), 64'h0);
        chk("areset_qv", 64'(qv0 | qv1), 64'h0);
        chk("areset_drained", 64'(dr0 & dr1), 64'h1);
        hist.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmp_model();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                $urandom_range(0, 1) == 1, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
